barrel_shifter: RTL and testbench

Registered 8-bit barrel shifter for the CPU datapath ALU, serving the shift and rotate instructions. It shifts or rotates an operand by 0–7 positions through a three-stage logarithmic multiplexer network. The result is captured in an output register, so the block adds exactly one clock of latency between the operand bus and the ALU result mux.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/shift_stage.sv | 36 +++
 rtl/barrel_shifter.sv | 54 +++++
 tb/tb_barrel_shifter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_pkg: shared CPU datapath constants (shift encodings, width).     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package cpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic [1:0] SHT_SLL = 2'b00;
    localparam logic [1:0] SHT_SRL = 2'b01;
    localparam logic [1:0] SHT_SRA = 2'b10;
    localparam logic [1:0] SHT_ROR = 2'b11;

endpackage
`default_nettype wire

// File: rtl/shift_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | shift_stage: one level of the log shifter, moves data by STEP bits.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module shift_stage
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STEP       = 1
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  en_i,
    input  logic [1:0]            shift_type_i,
    input  logic                  sign_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    logic [DATA_WIDTH-1:0] shifted;

    // The sign comes from the original operand so every stage fills alike.
    always_comb begin
        shifted = data_i;
        case (shift_type_i)
            SHT_SLL: shifted = {data_i[DATA_WIDTH-1-STEP:0], {STEP{1'b0}}};
            SHT_SRL: shifted = {{STEP{1'b0}}, data_i[DATA_WIDTH-1:STEP]};
            SHT_SRA: shifted = {{STEP{sign_i}}, data_i[DATA_WIDTH-1:STEP]};
            SHT_ROR: shifted = {data_i[STEP-1:0], data_i[DATA_WIDTH-1:STEP]};
            default: shifted = data_i;
        endcase
    end

    assign data_o = en_i ? shifted : data_i;

endmodule
`default_nettype wire

// File: rtl/barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | barrel_shifter: registered shift/rotate unit, one cycle of latency.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module barrel_shifter
    import cpu_pkg::*;
#(
    parameter  int DATA_WIDTH  = DATA_WIDTH_DEF,
    localparam int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [DATA_WIDTH-1:0]  INPUT,
    input  logic [SHAMT_WIDTH-1:0] SHIFT_AMOUNT,
    input  logic [1:0]             SHIFT_TYPE,
    output logic [DATA_WIDTH-1:0]  OUTPUT
);

    logic [DATA_WIDTH-1:0] stage_data [SHAMT_WIDTH+1];
    logic [DATA_WIDTH-1:0] result_d;
    logic [DATA_WIDTH-1:0] output_q;

    assign stage_data[0] = INPUT;

    generate
        for (genvar k = 0; k < SHAMT_WIDTH; k++) begin : g_stage
            shift_stage #(
                .DATA_WIDTH (DATA_WIDTH),
                .STEP       (1 << k)
            ) u_stage (
                .data_i       (stage_data[k]),
                .en_i         (SHIFT_AMOUNT[k]),
                .shift_type_i (SHIFT_TYPE),
                .sign_i       (INPUT[DATA_WIDTH-1]),
                .data_o       (stage_data[k+1])
            );
        end
    endgenerate

    assign result_d = stage_data[SHAMT_WIDTH];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            output_q <= '0;
        end else begin
            output_q <= result_d;
        end
    end

    assign OUTPUT = output_q;

endmodule
`default_nettype wire

// File: tb/tb_barrel_shifter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_barrel_shifter: directed and exhaustive checks of barrel_shifter. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_barrel_shifter;

    logic       CLK;
    logic       RESET;
    logic [7:0] INPUT;
    logic [2:0] SHIFT_AMOUNT;
    logic [1:0] SHIFT_TYPE;
    logic [7:0] OUTPUT;

    int n_cmp;
    int n_fail;

    barrel_shifter #(.DATA_WIDTH(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .INPUT        (INPUT),
        .SHIFT_AMOUNT (SHIFT_AMOUNT),
        .SHIFT_TYPE   (SHIFT_TYPE),
        .OUTPUT       (OUTPUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [7:0] ref_shift(input logic [7:0] a, input int n,
                                             input logic [1:0] t);
        logic [15:0] dbl;
        logic signed [7:0] s;
        dbl = {a, a} >> n;
        s = a;
        case (t)
            2'b00:   return a << n;
            2'b01:   return a >> n;
            2'b10:   return 8'(s >>> n);
            default: return dbl[7:0];
        endcase
    endfunction

    // Drive at the falling edge, then sample just after the next rising edge.
    task automatic op_cycle(input logic [7:0] a, input logic [2:0] n, input logic [1:0] t);
        @(negedge CLK);
        INPUT        = a;
        SHIFT_AMOUNT = n;
        SHIFT_TYPE   = t;
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        INPUT = 8'hFF; SHIFT_AMOUNT = 3'd0; SHIFT_TYPE = 2'b00;
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_initial: got %h expected 00", OUTPUT);
        end
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (OUTPUT !== 8'hFF) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected ff", OUTPUT);
        end
        // Asynchronous assertion away from any clock edge.
        #2;
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h expected 00", OUTPUT);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_held: got %h expected 00", OUTPUT);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_sll;
        logic [7:0] a   [3] = '{8'd16, 8'd4, 8'h81};
        logic [2:0] n   [3] = '{3'd2, 3'd2, 3'd7};
        logic [7:0] exp [3] = '{8'd64, 8'd16, 8'h80};
        for (int i = 0; i < 3; i++) begin
            op_cycle(a[i], n[i], 2'b00);
            n_cmp++;
            if (OUTPUT !== exp[i]) begin
                n_fail++;
                $display("FAIL sll_%0d: got %h expected %h", i, OUTPUT, exp[i]);
            end
        end
    endtask

    task automatic test_right;
        logic [1:0] t   [3] = '{2'b01, 2'b10, 2'b11};
        logic [7:0] exp [3] = '{8'h16, 8'hF6, 8'h96};
        for (int i = 0; i < 3; i++) begin
            op_cycle(8'hB4, 3'd3, t[i]);
            n_cmp++;
            if (OUTPUT !== exp[i]) begin
                n_fail++;
                $display("FAIL right_type%0d: got %h expected %h", t[i], OUTPUT, exp[i]);
            end
        end
    endtask

    task automatic test_exhaustive;
        logic [7:0] exp;
        for (int t = 0; t < 4; t++) begin
            for (int n = 0; n < 8; n++) begin
                for (int a = 0; a < 256; a++) begin
                    exp = ref_shift(8'(a), n, 2'(t));
                    op_cycle(8'(a), 3'(n), 2'(t));
                    n_cmp++;
                    if (OUTPUT !== exp) begin
                        n_fail++;
                        $display("FAIL exh a=%h n=%0d t=%0d: got %h expected %h",
                                 a[7:0], n, t, OUTPUT, exp);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] a   [5] = '{8'h3C, 8'h3C, 8'h80, 8'h01, 8'h5A};
        logic [2:0] n   [5] = '{3'd1, 3'd1, 3'd4, 3'd1, 3'd0};
        logic [1:0] t   [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
        logic [7:0] exp [5] = '{8'h78, 8'h1E, 8'hF8, 8'h80, 8'h5A};
        for (int i = 0; i < 5; i++) begin
            op_cycle(a[i], n[i], t[i]);
            n_cmp++;
            if (OUTPUT !== exp[i]) begin
                n_fail++;
                $display("FAIL b2b_%0d: got %h expected %h", i, OUTPUT, exp[i]);
            end
        end
        // New operands between edges must not disturb the held result.
        @(negedge CLK);
        INPUT = 8'hFF; SHIFT_AMOUNT = 3'd3; SHIFT_TYPE = 2'b00;
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h5A) begin
            n_fail++;
            $display("FAIL b2b_hold: got %h expected 5a", OUTPUT);
        end
        RESET = 1'b1;
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_reset_async: got %h expected 00", OUTPUT);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_pending_dropped: got %h expected 00", OUTPUT);
        end
        @(negedge CLK);
        RESET = 1'b0;
        INPUT = 8'hC3; SHIFT_AMOUNT = 3'd2; SHIFT_TYPE = 2'b11;
        #1;
        n_cmp++;
        if (OUTPUT !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_after_release: got %h expected 00", OUTPUT);
        end
        @(posedge CLK);
        #1;
        n_cmp++;
        if (OUTPUT !== 8'hF0) begin
            n_fail++;
            $display("FAIL b2b_resume: got %h expected f0", OUTPUT);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        test_reset();
        test_sll();
        test_right();
        test_exhaustive();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
